// File: rtl/lru8_repl_ctrl.sv
// lru8_repl_ctrl: 8-way tree-PLRU replacement controller with one 7-bit PLRU
// word per cache set.
//   clk, rstn           : clock, asynchronous active-low reset
//   way_enable          : per-way enable configuration (quasi-static)
//   hit_*               : hit reports; these update the set's PLRU word and are never stalled
//   alloc_req_*         : victim request (set index, per-way valid bits)
//   alloc_resp_*        : registered victim response (way, set, none flag)
//   lru_clear, busy     : clear-all request; busy while sets are being zeroed
module lru8_repl_ctrl #(
   parameter int unsigned SET_NUM   = 64,
   parameter int unsigned SET_IDX_W = $clog2(SET_NUM)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [7:0]           way_enable,
   input  logic                 hit_valid,
   input  logic [SET_IDX_W-1:0] hit_set_idx,
   input  logic [2:0]           hit_way_id,
   input  logic                 alloc_req_valid,
   output logic                 alloc_req_ready,
   input  logic [SET_IDX_W-1:0] alloc_set_idx,
   input  logic [7:0]           alloc_way_valid,
   output logic                 alloc_resp_valid,
   input  logic                 alloc_resp_ready,
   output logic [2:0]           alloc_resp_way_id,
   output logic [SET_IDX_W-1:0] alloc_resp_set_idx,
   output logic                 alloc_resp_none,
   input  logic                 lru_clear,
   output logic                 busy
);

   localparam int unsigned WAY_NUM = 8;
   localparam int unsigned WAY_W   = 3;
   localparam int unsigned LRU_W   = 7;

   typedef enum logic [1:0] {IDLE, PICK, RESP, CLEAR} state_t;

   state_t               state;
   logic [LRU_W-1:0]     lru [SET_NUM];
   logic                 clr_pend;
   logic [SET_IDX_W-1:0] clr_cnt;
   logic [SET_IDX_W-1:0] cap_set;
   logic [WAY_NUM-1:0]   cap_valid;

   logic [WAY_NUM-1:0]   cand;
   logic [WAY_W-1:0]     pick_way;
   logic                 pick_none;
   logic                 resp_hs;
   logic [LRU_W-1:0]     alloc_base;

   // Point the tree away from the accessed way.
   function automatic logic [LRU_W-1:0] lru_touch(input logic [LRU_W-1:0] word,
                                                  input logic [WAY_W-1:0] w);
      logic [LRU_W-1:0] r;
      r = word;
      r[6] = w[2];
      if (!w[2]) r[4] = w[1];
      else       r[5] = w[1];
      r[{1'b0, w[2:1]}] = w[0];
      return r;
   endfunction

   // Root-to-leaf walk: take the preferred side unless it has no enabled way.
   // A set bit prefers the lower-index side. Caller guarantees en != 0.
   function automatic logic [WAY_W-1:0] tree_walk(input logic [LRU_W-1:0] word,
                                                  input logic [WAY_NUM-1:0] en);
      logic       hi;
      logic [1:0] pair;
      logic       leaf;
      hi = word[6] ? (en[3:0] == 4'h0) : (en[7:4] != 4'h0);
      pair[1] = hi;
      if (!hi) pair[0] = word[4] ? (en[1:0] == 2'b00) : (en[3:2] != 2'b00);
      else     pair[0] = word[5] ? (en[5:4] == 2'b00) : (en[7:6] != 2'b00);
      leaf = word[{1'b0, pair}] ? !en[{pair, 1'b0}] : en[{pair, 1'b1}];
      return {pair, leaf};
   endfunction

   // Victim selection for the captured request.
   always_comb begin
      cand      = ~cap_valid & way_enable;
      pick_way  = '0;
      pick_none = 1'b0;
      if (way_enable == '0) begin
         pick_none = 1'b1;
      end else if (cand != '0) begin
         for (int i = WAY_NUM - 1; i >= 0; i--) begin
            if (cand[i]) pick_way = WAY_W'(i);
         end
      end else begin
         pick_way = tree_walk(lru[cap_set], way_enable);
      end
   end

   // Same-set hit in the handshake cycle is applied before the alloc update.
   always_comb begin
      resp_hs = (state == RESP) && alloc_resp_valid && alloc_resp_ready;
      if (hit_valid && (hit_set_idx == alloc_resp_set_idx))
         alloc_base = lru_touch(lru[hit_set_idx], hit_way_id);
      else
         alloc_base = lru[alloc_resp_set_idx];
   end

   assign alloc_req_ready = (state == IDLE) && !lru_clear && !clr_pend;

   // Control FSM, registered outputs and PLRU storage.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state              <= IDLE;
         clr_pend           <= 1'b0;
         clr_cnt            <= '0;
         cap_set            <= '0;
         cap_valid          <= '0;
         alloc_resp_valid   <= 1'b0;
         alloc_resp_way_id  <= '0;
         alloc_resp_set_idx <= '0;
         alloc_resp_none    <= 1'b0;
         busy               <= 1'b0;
         for (int s = 0; s < int'(SET_NUM); s++) lru[s] <= '0;
      end else begin
         if (state == CLEAR) begin
            lru[clr_cnt] <= '0;
         end else begin
            if (hit_valid)
               lru[hit_set_idx] <= lru_touch(lru[hit_set_idx], hit_way_id);
            // Later assignment wins when both target the same set.
            if (resp_hs && !alloc_resp_none)
               lru[alloc_resp_set_idx] <= lru_touch(alloc_base, alloc_resp_way_id);
         end

         case (state)
            IDLE: begin
               if (lru_clear || clr_pend) begin
                  state    <= CLEAR;
                  busy     <= 1'b1;
                  clr_pend <= 1'b0;
                  clr_cnt  <= '0;
               end else if (alloc_req_valid) begin
                  state     <= PICK;
                  cap_set   <= alloc_set_idx;
                  cap_valid <= alloc_way_valid;
               end
            end
            PICK: begin
               if (lru_clear) clr_pend <= 1'b1;
               alloc_resp_valid   <= 1'b1;
               alloc_resp_way_id  <= pick_way;
               alloc_resp_set_idx <= cap_set;
               alloc_resp_none    <= pick_none;
               state              <= RESP;
            end
            RESP: begin
               if (lru_clear) clr_pend <= 1'b1;
               if (alloc_resp_ready) begin
                  alloc_resp_valid <= 1'b0;
                  state            <= IDLE;
               end
            end
            CLEAR: begin
               clr_cnt <= clr_cnt + SET_IDX_W'(1);
               if (clr_cnt == SET_IDX_W'(SET_NUM - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
